// File: rtl/slc3_io_pkg.sv
// Shared constants and types for the SLC-3 board I/O conditioning blocks.
package slc3_io_pkg;
  localparam int DEBOUNCE_DEFAULT = 500000;  // 10 ms at 50 MHz
  localparam int SIM_DEBOUNCE     = 8;
  localparam int NUM_BTN          = 2;

  typedef enum logic {BTN_RUN = 1'b0, BTN_CONT = 1'b1} btn_idx_t;
endpackage

// File: rtl/btn_conditioner_if.sv
// Raw board inputs and conditioned outputs between the board pins and slc3/ISDU.
interface btn_conditioner_if #(parameter int SW_WIDTH = 16);
  logic                Run_raw;
  logic                Continue_raw;
  logic [SW_WIDTH-1:0] S_raw;
  logic                Run;
  logic                Continue;
  logic                Run_pulse;
  logic                Cont_pulse;
  logic [SW_WIDTH-1:0] S;

  modport master (output Run_raw, Continue_raw, S_raw,
                  input  Run, Continue, Run_pulse, Cont_pulse, S);
  modport slave  (input  Run_raw, Continue_raw, S_raw,
                  output Run, Continue, Run_pulse, Cont_pulse, S);
endinterface

// File: rtl/btn_debounce.sv
// One active-low push button: 2-flop sync, stability counter, stable level and press pulse.
module btn_debounce
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TERM) begin
        level <= sync[1];
        cnt   <= '0;
        // only a 1->0 transition (press) pulses; level still holds the old value here
        pulse <= level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// Board input conditioner: debounced Run/Continue levels and press pulses, synced switches.
module btn_conditioner
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SW_WIDTH        = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  btn_conditioner_if.slave  io
);
  logic [NUM_BTN-1:0] raw_v;
  logic [NUM_BTN-1:0] lvl_v;
  logic [NUM_BTN-1:0] pls_v;

  assign raw_v[BTN_RUN]  = io.Run_raw;
  assign raw_v[BTN_CONT] = io.Continue_raw;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NUM_BTN-1:0] (
    .Clk   (Clk),
    .Reset (Reset),
    .raw   (raw_v),
    .level (lvl_v),
    .pulse (pls_v)
  );

  assign io.Run        = lvl_v[BTN_RUN];
  assign io.Continue   = lvl_v[BTN_CONT];
  assign io.Run_pulse  = pls_v[BTN_RUN];
  assign io.Cont_pulse = pls_v[BTN_CONT];

  // switches are static levels, so synchronise only
  logic [1:0][SW_WIDTH-1:0] s_sync;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) s_sync <= '0;
    else        s_sync <= {s_sync[0], io.S_raw};
  end

  assign io.S = s_sync[1];
endmodule
